ioctl_cfg_loader: RTL and testbench
===================================

Name: ioctl_cfg_loader

Overview:
- Parametrised configuration loader between hps_io and the arcade core.
- Captures the per-game module-select byte and N DIP bytes delivered over the ioctl download channel into shadow registers.
- Commits them atomically to the core at the end of each download session, and registers a one-hot module decode.
- Generates a stretched core reset request covering ROM download and any module change; replaces ad-hoc per-core mod/sw capture logic.

Parameters:
- NUM_MODS, 18: number of supported game modules; width of the one-hot output.
- DIP_BYTES, 8: number of DIP bytes captured (1..32).
- ADDR_W, 25: ioctl address width.
- ROM_INDEX, 0: ioctl_index value of the ROM download.
- MOD_INDEX, 1: ioctl_index value of the module-select download.
- DIP_INDEX, 254: ioctl_index value of the DIP download.
- RST_CYCLES, 16: length of the post-download core reset stretch, in clk_sys cycles (>=1).

Ports:
- clk_sys, in, 1: system clock; all logic on rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- ioctl_download, in, 1: download session active.
- ioctl_wr, in, 1: one-cycle byte write strobe.
- ioctl_index, in, 8: download target index; stable while ioctl_download=1.
- ioctl_addr, in, ADDR_W: byte address within the session.
- ioctl_dout, in, 8: write data.
- mod_id, out, 8: committed module number.
- mod_onehot, out, NUM_MODS: registered decode, bit k = (mod_id==k).
- mod_valid, out, 1: mod_id < NUM_MODS.
- dip_bank, out, 8*DIP_BYTES: committed DIP bytes; byte i at [8i+7:8i].
- cfg_valid, out, 1: at least one MOD commit and one DIP commit since reset.
- rom_busy, out, 1: ROM session in progress.
- core_reset, out, 1: active-high reset request to the core.

Behaviour:
- Reset values (async, reset_n=0):
  - mod_id=0, mod_onehot=1 (bit0), mod_valid=1, dip_bank all 1s, cfg_valid=0, rom_busy=0, core_reset=1.
  - Shadows cleared to the same values; session state idle; reset counter loaded with RST_CYCLES.
- Session tracking:
  - dl_q = registered ioctl_download.
  - Rising edge (download=1, dl_q=0): latch sess_idx=ioctl_index, set sess_act=1.
  - Falling edge (download=0, dl_q=1) with sess_act=1: end event, then clear sess_act.
  - A falling edge with sess_act=0 (reset occurred mid-session) produces no commit and no end event.
- Capture, only when ioctl_wr=1 and ioctl_download=1 and sess_act=1:
  - MOD session, ioctl_addr==0: mod_sh <= ioctl_dout. Other addresses are ignored.
  - DIP session, ioctl_addr < DIP_BYTES: dip_sh[addr] <= ioctl_dout. Higher addresses are ignored; unwritten bytes keep their previous shadow value.
  - Writes while ioctl_download=0 are ignored. ROM-session writes are not captured.
- Commit, registered on the end-event cycle:
  - MOD session: mod_id <= mod_sh, mod_seen <= 1.
  - DIP session: dip_bank <= dip_sh, dip_seen <= 1.
  - Session with no writes: commits the unchanged shadow (idempotent).
  - mod_onehot and mod_valid update one cycle after mod_id (latency 2 from the falling edge).
  - mod_id >= NUM_MODS gives mod_onehot=0 and mod_valid=0.
  - cfg_valid = mod_seen & dip_seen, registered; cleared only by reset.
- rom_busy = sess_act && sess_idx==ROM_INDEX, registered.
- core_reset state machine, states RUN, HOLD, STRETCH:
  - Reset enters STRETCH with cnt=RST_CYCLES.
  - RUN -> HOLD on a ROM session start.
  - HOLD -> STRETCH (cnt=RST_CYCLES) on the ROM session end event.
  - RUN -> STRETCH on a MOD commit whose mod_sh differs from the current mod_id. An equal value does not reset.
  - STRETCH decrements cnt each cycle and -> RUN on the cycle cnt reaches 1.
  - core_reset=1 in HOLD and STRETCH.
  - A ROM session start during STRETCH -> HOLD.
  - A MOD change during STRETCH reloads cnt=RST_CYCLES.
  - DIP commits never assert core_reset.
- Pulse width: exactly RST_CYCLES cycles of core_reset after leaving HOLD or after the triggering commit cycle.

Test Plan:
- Release reset_n -> core_reset high 16 cycles then low; mod_onehot=18'h00001; dip_bank all FF; cfg_valid=0.
- MOD session (index 1) writing 0x05 at addr 0 -> mod_id=5 on the end-event cycle; mod_onehot=18'h00020 one cycle later; core_reset high exactly 16 cycles. Repeat with 0x05 -> no core_reset.
- DIP session (index 254) writing addr0..9 = 0x10..0x19 -> dip_bank bytes 0..7 = 0x10..0x17 only at session end; dip_bank unchanged mid-session; cfg_valid=1 after both MOD and DIP commits.
- ROM session (index 0) of 100 writes -> rom_busy and core_reset high throughout, core_reset held 16 cycles past the falling edge; dip_bank and mod_id unchanged.
- MOD session with 0x14 (>=18) -> mod_valid=0, mod_onehot=0. Then assert reset_n=0 mid MOD session, release, finish the session -> no commit, mod_id=0.
- ROM session starting during a MOD-triggered stretch -> core_reset stays high continuously, no glitch low, 16 cycles after the ROM end.

Source files
------------

// File: rtl/ioctl_cfg_loader.sv
// ioctl_cfg_loader
// ----------------
// Configuration loader between hps_io and the arcade core. The module-select
// byte and the DIP bytes arrive over the ioctl download channel. They are
// captured into shadow registers while a session is running. At the end of
// each session they are committed to the core in one step. A one-hot module
// decode is registered from the committed module number. A stretched reset
// request is generated for the core. It covers ROM downloads and any change
// of the selected module.
//
// Ports
//   clk_sys         system clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset
//   ioctl_download  download session active
//   ioctl_wr        one-cycle byte write strobe
//   ioctl_index     download target index, stable during a session
//   ioctl_addr      byte address within the session
//   ioctl_dout      write data
//   mod_id          committed module number
//   mod_onehot      registered decode, bit k set when mod_id == k
//   mod_valid       mod_id is below NUM_MODS
//   dip_bank        committed DIP bytes, byte i at [8i+7:8i]
//   cfg_valid       a MOD and a DIP commit have both happened since reset
//   rom_busy        ROM session in progress
//   core_reset      active-high reset request to the core

module ioctl_cfg_loader #(
    parameter int         NUM_MODS   = 18,
    parameter int         DIP_BYTES  = 8,
    parameter int         ADDR_W     = 25,
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter logic [7:0] MOD_INDEX  = 8'd1,
    parameter logic [7:0] DIP_INDEX  = 8'd254,
    parameter int         RST_CYCLES = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [7:0]             mod_id,
    output logic [NUM_MODS-1:0]    mod_onehot,
    output logic                   mod_valid,
    output logic [8*DIP_BYTES-1:0] dip_bank,
    output logic                   cfg_valid,
    output logic                   rom_busy,
    output logic                   core_reset
);

    localparam int             CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        STRETCH = 2'd2
    } RstState_t;

    logic                   dl_q;
    logic                   sessAct_q;
    logic [7:0]             sessIdx_q;
    logic [7:0]             modSh_q;
    logic [8*DIP_BYTES-1:0] dipSh_q;
    logic [7:0]             modId_q;
    logic [NUM_MODS-1:0]    modOnehot_q;
    logic                   modValid_q;
    logic [8*DIP_BYTES-1:0] dipBank_q;
    logic                   modSeen_q;
    logic                   dipSeen_q;
    logic                   cfgValid_q;
    logic                   romBusy_q;
    RstState_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   coreReset_q;

    logic                   startEvt;
    logic                   endEvt;
    logic                   sessIsMod;
    logic                   sessIsDip;
    logic                   sessIsRom;
    logic                   wrEn;
    logic                   romStart;
    logic                   romEnd;
    logic                   modChange;
    logic [NUM_MODS-1:0]    modOnehot_d;
    logic                   modValid_d;

    // Session edge detection and the events derived from it. An end event
    // needs a live session. A falling edge after a reset in the middle of
    // a session therefore commits nothing.
    always_comb begin
        startEvt  = ioctl_download & ~dl_q;
        endEvt    = ~ioctl_download & dl_q & sessAct_q;
        sessIsMod = (sessIdx_q == MOD_INDEX);
        sessIsDip = (sessIdx_q == DIP_INDEX);
        sessIsRom = (sessIdx_q == ROM_INDEX);
        wrEn      = ioctl_wr & ioctl_download & sessAct_q;
        romStart  = startEvt & (ioctl_index == ROM_INDEX);
        romEnd    = endEvt & sessIsRom;
        modChange = endEvt & sessIsMod & (modSh_q != modId_q);
    end

    // Decode of the committed module number. It is registered one cycle
    // behind mod_id. Values outside the module range decode to all zeros.
    always_comb begin
        modOnehot_d = '0;
        for (int k = 0; k < NUM_MODS; k++) begin
            modOnehot_d[k] = ({24'd0, modId_q} == 32'(k));
        end
        modValid_d = ({24'd0, modId_q} < 32'(NUM_MODS));
    end

    // Session tracking. dl_q comes out of reset high. This stops a download
    // that is still asserted when reset is released from looking like a new
    // session, so the rest of that session is ignored.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q      <= 1'b1;
            sessAct_q <= 1'b0;
            sessIdx_q <= 8'd0;
        end else begin
            dl_q <= ioctl_download;
            if (startEvt) begin
                sessAct_q <= 1'b1;
                sessIdx_q <= ioctl_index;
            end else if (!ioctl_download) begin
                sessAct_q <= 1'b0;
            end
        end
    end

    // Shadow capture. Only writes inside a live MOD or DIP session are
    // taken. Out-of-range addresses leave the shadows alone. DIP bytes that
    // are not rewritten keep their earlier value.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            modSh_q <= 8'd0;
            dipSh_q <= '1;
        end else if (wrEn) begin
            if (sessIsMod && ioctl_addr == '0) begin
                modSh_q <= ioctl_dout;
            end
            if (sessIsDip) begin
                for (int i = 0; i < DIP_BYTES; i++) begin
                    if (ioctl_addr == ADDR_W'(i)) begin
                        dipSh_q[8*i +: 8] <= ioctl_dout;
                    end
                end
            end
        end
    end

    // Commit of the shadows on the end-event cycle. This block also
    // registers the decode, the sticky config-valid flag and the ROM busy
    // flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            modId_q     <= 8'd0;
            modOnehot_q <= NUM_MODS'(1);
            modValid_q  <= 1'b1;
            dipBank_q   <= '1;
            modSeen_q   <= 1'b0;
            dipSeen_q   <= 1'b0;
            cfgValid_q  <= 1'b0;
            romBusy_q   <= 1'b0;
        end else begin
            if (endEvt && sessIsMod) begin
                modId_q   <= modSh_q;
                modSeen_q <= 1'b1;
            end
            if (endEvt && sessIsDip) begin
                dipBank_q <= dipSh_q;
                dipSeen_q <= 1'b1;
            end
            modOnehot_q <= modOnehot_d;
            modValid_q  <= modValid_d;
            cfgValid_q  <= modSeen_q & dipSeen_q;
            romBusy_q   <= sessAct_q & sessIsRom;
        end
    end

    // Core reset sequencer. HOLD keeps the core in reset for the whole ROM
    // download. STRETCH counts RST_CYCLES cycles down and then releases the
    // core. core_reset is registered from the next state, so it never
    // glitches low when one reset cause hands over to another.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= STRETCH;
            cnt_q       <= CNT_LOAD;
            coreReset_q <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (romStart) begin
                        state_q     <= HOLD;
                        coreReset_q <= 1'b1;
                    end else if (modChange) begin
                        state_q     <= STRETCH;
                        cnt_q       <= CNT_LOAD;
                        coreReset_q <= 1'b1;
                    end else begin
                        coreReset_q <= 1'b0;
                    end
                end
                HOLD: begin
                    coreReset_q <= 1'b1;
                    if (romEnd) begin
                        state_q <= STRETCH;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                STRETCH: begin
                    if (romStart) begin
                        state_q     <= HOLD;
                        coreReset_q <= 1'b1;
                    end else if (modChange) begin
                        cnt_q       <= CNT_LOAD;
                        coreReset_q <= 1'b1;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q     <= RUN;
                        coreReset_q <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q - CNT_W'(1);
                        coreReset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= RUN;
                    coreReset_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping, all straight from registers.
    assign mod_id     = modId_q;
    assign mod_onehot = modOnehot_q;
    assign mod_valid  = modValid_q;
    assign dip_bank   = dipBank_q;
    assign cfg_valid  = cfgValid_q;
    assign rom_busy   = romBusy_q;
    assign core_reset = coreReset_q;

endmodule

// File: tb/tb_ioctl_cfg_loader.sv
// tb_ioctl_cfg_loader
// -------------------
// Directed and randomized download sessions for ioctl_cfg_loader. A small
// behavioural model tracks the shadows, the committed configuration and the
// expected length of each core reset pulse.
//
// Ports: none (top-level bench).

module tb_ioctl_cfg_loader;

    localparam int         NUM_MODS  = 18;
    localparam int         DIP_BYTES = 8;
    localparam int         ADDR_W    = 25;
    localparam logic [7:0] ROM_IDX   = 8'd0;
    localparam logic [7:0] MOD_IDX   = 8'd1;
    localparam logic [7:0] DIP_IDX   = 8'd254;
    localparam int         RST       = 16;

    logic                   clk_sys = 1'b0;
    logic                   reset_n;
    logic                   ioctl_download;
    logic                   ioctl_wr;
    logic [7:0]             ioctl_index;
    logic [ADDR_W-1:0]      ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [7:0]             mod_id;
    logic [NUM_MODS-1:0]    mod_onehot;
    logic                   mod_valid;
    logic [8*DIP_BYTES-1:0] dip_bank;
    logic                   cfg_valid;
    logic                   rom_busy;
    logic                   core_reset;

    int   checks = 0;
    int   failures = 0;
    int   pulseHighs = 0;
    int   pulseFalls = 0;
    logic pulsePrev = 1'b0;

    logic [7:0] modelModSh;
    logic [7:0] modelModId;
    logic [7:0] modelDipSh [DIP_BYTES];
    logic [7:0] modelDip   [DIP_BYTES];
    bit         modelModSeen;
    bit         modelDipSeen;

    // Free-running system clock.
    always #5 clk_sys = ~clk_sys;

    ioctl_cfg_loader #(
        .NUM_MODS  (NUM_MODS),
        .DIP_BYTES (DIP_BYTES),
        .ADDR_W    (ADDR_W),
        .ROM_INDEX (ROM_IDX),
        .MOD_INDEX (MOD_IDX),
        .DIP_INDEX (DIP_IDX),
        .RST_CYCLES(RST)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_index   (ioctl_index),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .mod_id        (mod_id),
        .mod_onehot    (mod_onehot),
        .mod_valid     (mod_valid),
        .dip_bank      (dip_bank),
        .cfg_valid     (cfg_valid),
        .rom_busy      (rom_busy),
        .core_reset    (core_reset)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs. Before moving on to the next falling
    // edge it samples core_reset, counting high cycles and high-to-low
    // transitions.
    task automatic applyStimulus(input logic dl, input logic wr, input logic [7:0] idx,
                                 input logic [ADDR_W-1:0] addr, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_index    = idx;
        ioctl_addr     = addr;
        ioctl_dout     = dout;
        if (core_reset === 1'b1) pulseHighs++;
        else if (pulsePrev) pulseFalls++;
        pulsePrev = (core_reset === 1'b1);
        @(negedge clk_sys);
    endtask

    task automatic pulseReset();
        pulseHighs = 0;
        pulseFalls = 0;
        pulsePrev  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'd0, '0, 8'd0);
    endtask

    function automatic logic [63:0] expOnehot(input logic [7:0] id);
        return (int'(id) < NUM_MODS) ? (64'd1 << id) : 64'd0;
    endfunction

    function automatic logic [63:0] packDip();
        logic [63:0] r;
        for (int i = 0; i < DIP_BYTES; i++) r[8*i +: 8] = modelDip[i];
        return r;
    endfunction

    task automatic modelReset();
        modelModSh   = 8'd0;
        modelModId   = 8'd0;
        modelModSeen = 0;
        modelDipSeen = 0;
        for (int i = 0; i < DIP_BYTES; i++) begin
            modelDipSh[i] = 8'hFF;
            modelDip[i]   = 8'hFF;
        end
    endtask

    // Two idle cycles at the start, so the session is live before any
    // write arrives.
    task automatic startSession(input logic [7:0] idx);
        applyStimulus(1'b1, 1'b0, idx, '0, 8'd0);
        applyStimulus(1'b1, 1'b0, idx, '0, 8'd0);
    endtask

    task automatic writeByte(input logic [7:0] idx, input int addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, idx, ADDR_W'(addr), data);
        if (idx == MOD_IDX && addr == 0) modelModSh = data;
        if (idx == DIP_IDX && addr < DIP_BYTES) modelDipSh[addr] = data;
    endtask

    // Ends a session and returns the expected core reset pulse length.
    task automatic endSession(input logic [7:0] idx, output int expPulse);
        applyStimulus(1'b0, 1'b0, idx, '0, 8'd0);
        expPulse = 0;
        if (idx == MOD_IDX) begin
            if (modelModSh != modelModId) expPulse = RST;
            modelModId   = modelModSh;
            modelModSeen = 1;
        end else if (idx == DIP_IDX) begin
            for (int i = 0; i < DIP_BYTES; i++) modelDip[i] = modelDipSh[i];
            modelDipSeen = 1;
        end else if (idx == ROM_IDX) begin
            expPulse = RST;
        end
    endtask

    // One MOD session with junk writes to non-zero addresses. It checks
    // the commit timing, the decode lag and the reset pulse length.
    task automatic modSessionCheck(input string name, input logic [7:0] value, input bit doWrite);
        logic [63:0] prevOne;
        int          ep;
        startSession(MOD_IDX);
        writeByte(MOD_IDX, int'($urandom_range(1, 30)), 8'($urandom));
        if (doWrite) writeByte(MOD_IDX, 0, value);
        writeByte(MOD_IDX, int'($urandom_range(1, 30)), 8'($urandom));
        prevOne = expOnehot(modelModId);
        endSession(MOD_IDX, ep);
        pulseReset();
        checkOutput({name, ".modId"}, 64'(mod_id), 64'(modelModId));
        checkOutput({name, ".onehotLag"}, 64'(mod_onehot), prevOne);
        applyStimulus(1'b0, 1'b0, 8'd0, '0, 8'd0);
        checkOutput({name, ".onehot"}, 64'(mod_onehot), expOnehot(modelModId));
        checkOutput({name, ".modValid"}, 64'(mod_valid), 64'(int'(modelModId) < NUM_MODS));
        idle(30);
        checkOutput({name, ".pulseLen"}, 64'(pulseHighs), 64'(ep));
        checkOutput({name, ".pulseFalls"}, 64'(pulseFalls), 64'(ep > 0 ? 1 : 0));
    endtask

    // DIP session end: the bank updates, the config-valid flag follows,
    // and core_reset never rises.
    task automatic dipFinish(input string name);
        int ep;
        endSession(DIP_IDX, ep);
        pulseReset();
        idle(3);
        checkOutput({name, ".bank"}, dip_bank, packDip());
        checkOutput({name, ".cfgValid"}, 64'(cfg_valid), 64'(modelModSeen && modelDipSeen));
        idle(20);
        checkOutput({name, ".noReset"}, 64'(pulseHighs), 64'(ep));
    endtask

    // Directed sequence with randomized data and addresses.
    initial begin
        int ep;
        int bad;
        int cyc;
        logic [7:0] v;

        modelReset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'd0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        checkOutput("rst.modId", 64'(mod_id), 64'd0);
        checkOutput("rst.onehot", 64'(mod_onehot), 64'h1);
        checkOutput("rst.modValid", 64'(mod_valid), 64'd1);
        checkOutput("rst.dipBank", dip_bank, {64{1'b1}});
        checkOutput("rst.cfgValid", 64'(cfg_valid), 64'd0);
        checkOutput("rst.romBusy", 64'(rom_busy), 64'd0);
        checkOutput("rst.coreReset", 64'(core_reset), 64'd1);
        reset_n = 1'b1;
        pulseReset();
        idle(30);
        checkOutput("rst.pulseLen", 64'(pulseHighs), 64'(RST));
        checkOutput("rst.pulseFalls", 64'(pulseFalls), 64'd1);

        modSessionCheck("mod5", 8'h05, 1'b1);
        checkOutput("mod5.cfgValid", 64'(cfg_valid), 64'd0);
        modSessionCheck("mod5again", 8'h05, 1'b1);

        // A write while no download is active must be ignored.
        applyStimulus(1'b0, 1'b1, MOD_IDX, '0, 8'hAA);
        modSessionCheck("stray", 8'h00, 1'b0);

        startSession(DIP_IDX);
        for (int a = 0; a < 10; a++) writeByte(DIP_IDX, a, 8'(8'h10 + a));
        checkOutput("dip.midSession", dip_bank, packDip());
        dipFinish("dip");

        startSession(DIP_IDX);
        repeat ($urandom_range(1, 12)) writeByte(DIP_IDX, int'($urandom_range(0, 11)), 8'($urandom));
        dipFinish("dipRnd");

        startSession(ROM_IDX);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(core_reset === 1'b1 && rom_busy === 1'b1)) bad++;
            writeByte(ROM_IDX, int'($urandom_range(0, 20)), 8'($urandom));
        end
        checkOutput("rom.busyHeld", 64'(bad), 64'd0);
        endSession(ROM_IDX, ep);
        pulseReset();
        idle(30);
        checkOutput("rom.pulseLen", 64'(pulseHighs), 64'(ep));
        checkOutput("rom.romBusyAfter", 64'(rom_busy), 64'd0);
        checkOutput("rom.modId", 64'(mod_id), 64'(modelModId));
        checkOutput("rom.dipBank", dip_bank, packDip());

        for (int i = 0; i < 4; i++) begin
            modSessionCheck($sformatf("rnd%0d", i), 8'($urandom_range(0, 25)), $urandom_range(0, 3) != 0);
        end

        modSessionCheck("mod20", 8'h14, 1'b1);

        // A ROM session that starts during a module-change stretch must keep
        // core_reset high with no gap.
        v = 8'($urandom_range(1, 17));
        startSession(MOD_IDX);
        writeByte(MOD_IDX, 0, v);
        endSession(MOD_IDX, ep);
        pulseReset();
        cyc = 0;
        idle(5);
        cyc += 5;
        startSession(ROM_IDX);
        cyc += 2;
        for (int i = 0; i < 20; i++) begin
            writeByte(ROM_IDX, int'($urandom_range(0, 20)), 8'($urandom));
            cyc++;
        end
        endSession(ROM_IDX, ep);
        cyc++;
        idle(30);
        checkOutput("glitch.pulseLen", 64'(pulseHighs), 64'(cyc + RST));
        checkOutput("glitch.pulseFalls", 64'(pulseFalls), 64'd1);
        checkOutput("glitch.modId", 64'(mod_id), 64'(v));

        // Reset in the middle of a MOD session: the rest of that session
        // commits nothing.
        startSession(MOD_IDX);
        writeByte(MOD_IDX, 0, 8'h0B);
        reset_n = 1'b0;
        modelReset();
        applyStimulus(1'b1, 1'b0, MOD_IDX, '0, 8'd0);
        checkOutput("midRst.modIdInRst", 64'(mod_id), 64'd0);
        checkOutput("midRst.coreReset", 64'(core_reset), 64'd1);
        applyStimulus(1'b1, 1'b0, MOD_IDX, '0, 8'd0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, MOD_IDX, '0, 8'h0C);
        applyStimulus(1'b1, 1'b0, MOD_IDX, '0, 8'd0);
        applyStimulus(1'b0, 1'b0, MOD_IDX, '0, 8'd0);
        checkOutput("midRst.noCommit", 64'(mod_id), 64'd0);
        idle(30);
        checkOutput("midRst.modIdLater", 64'(mod_id), 64'd0);
        checkOutput("midRst.onehot", 64'(mod_onehot), 64'h1);
        checkOutput("midRst.cfgValid", 64'(cfg_valid), 64'd0);
        checkOutput("midRst.dipBank", dip_bank, {64{1'b1}});
        checkOutput("midRst.coreRelease", 64'(core_reset), 64'd0);
        modSessionCheck("postRst", 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
